// File: rtl/mac_arbiter.sv
// Round-robin issue scheduler for one shared pipelined multiply-add unit.
// Tags each issued op with its requester ID and returns the result to it, with a flush/drain handshake.
module mac_arbiter #(
    parameter int P   = 8,
    parameter int N   = 4,
    parameter int LAT = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(LAT + 3)
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic [N-1:0]     REQ,
    input  logic [N*P-1:0]   REQ_A,
    input  logic [N*P-1:0]   REQ_B,
    input  logic [N*P-1:0]   REQ_C,
    output logic [N-1:0]     GNT,
    output logic [P-1:0]     A1_O,
    output logic [P-1:0]     B1_O,
    output logic [P-1:0]     C1_O,
    input  logic [2*P-1:0]   MAC_Q,
    output logic             RSP_VALID,
    output logic [IW-1:0]    RSP_ID,
    output logic [2*P-1:0]   RSP_DATA,
    input  logic             FLUSH,
    output logic             FLUSH_DONE,
    output logic             BUSY
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} stateType;

    stateType               state, stateNext;
    logic [IW-1:0]          ptr, ptrNext, gntId, cand;
    logic                   issue;
    logic [N-1:0][P-1:0]    reqA, reqB, reqC;
    logic [LAT:0]           vldPipe;
    logic [LAT:0][IW-1:0]   idPipe;
    logic [CW-1:0]          inFlight;

    assign reqA = REQ_A;
    assign reqB = REQ_B;
    assign reqC = REQ_C;

    // Search starts at ptr and wraps; the first asserted request wins.
    always_comb begin
        GNT   = '0;
        gntId = '0;
        cand  = '0;
        issue = 1'b0;
        if (!R && state == RUN && EN && !FLUSH) begin
            for (int k = 0; k < N; k++) begin
                cand = IW'((int'(ptr) + k) % N);
                if (!issue && REQ[cand]) begin
                    issue      = 1'b1;
                    gntId      = cand;
                    GNT[cand]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptrNext = ptr;
        if (issue)
            ptrNext = (int'(gntId) == N - 1) ? '0 : gntId + 1'b1;
    end

    always_comb begin
        stateNext  = state;
        FLUSH_DONE = 1'b0;
        case (state)
            RUN:     if (FLUSH) stateNext = DRAIN;
            DRAIN:   if (inFlight == '0) stateNext = DONE;
            DONE: begin
                FLUSH_DONE = 1'b1;
                stateNext  = RUN;
            end
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state <= RUN;
            ptr   <= '0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            A1_O <= '0;
            B1_O <= '0;
            C1_O <= '0;
        end else if (issue) begin
            A1_O <= reqA[gntId];
            B1_O <= reqB[gntId];
            C1_O <= reqC[gntId];
        end
    end

    // Tag stage LAT lines up with MAC_Q; clearing it on reset drops results of lost ops.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            vldPipe <= '0;
            idPipe  <= '0;
        end else begin
            vldPipe <= {vldPipe[LAT-1:0], issue};
            idPipe  <= {idPipe[LAT-1:0], gntId};
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            RSP_VALID <= 1'b0;
            RSP_ID    <= '0;
            RSP_DATA  <= '0;
        end else begin
            RSP_VALID <= vldPipe[LAT];
            RSP_ID    <= idPipe[LAT];
            if (vldPipe[LAT])
                RSP_DATA <= MAC_Q;
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            inFlight <= '0;
        end else begin
            case ({issue, RSP_VALID})
                2'b10:   inFlight <= inFlight + 1'b1;
                2'b01:   inFlight <= inFlight - 1'b1;
                default: inFlight <= inFlight;
            endcase
        end
    end

    assign BUSY = (inFlight != '0);

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: a behavioural 4-stage multiply-add unit, stimulus that
// queues hand-computed responses, and a monitor that checks ID, data and arrival cycle.
module tb_mac_arbiter;
    localparam int P = 8, N = 4, LAT = 4, IW = 2;

    logic             C = 1'b0, R = 1'b1, EN = 1'b0, FLUSH = 1'b0;
    logic [N-1:0]     REQ = '0;
    logic [N*P-1:0]   REQ_A = '0, REQ_B = '0, REQ_C = '0;
    logic [N-1:0]     GNT;
    logic [P-1:0]     A1_O, B1_O, C1_O;
    logic [2*P-1:0]   MAC_Q;
    logic             RSP_VALID, FLUSH_DONE, BUSY;
    logic [IW-1:0]    RSP_ID;
    logic [2*P-1:0]   RSP_DATA;

    mac_arbiter #(.P(P), .N(N), .LAT(LAT)) dut (
        .C(C), .R(R), .EN(EN), .REQ(REQ),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_C(REQ_C),
        .GNT(GNT), .A1_O(A1_O), .B1_O(B1_O), .C1_O(C1_O),
        .MAC_Q(MAC_Q), .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
        .FLUSH(FLUSH), .FLUSH_DONE(FLUSH_DONE), .BUSY(BUSY)
    );

    always #5 C = ~C;

    // Multiply-add unit: 4 register stages, never reset.
    logic [2*P-1:0] mac [LAT] = '{default: '0};
    always @(posedge C) begin
        mac[0] <= 16'(A1_O) * 16'(B1_O) + 16'(C1_O);
        for (int i = 1; i < LAT; i++) mac[i] <= mac[i-1];
    end
    assign MAC_Q = mac[LAT-1];

    int cyc = 0;
    always @(posedge C) cyc <= cyc + 1;

    typedef struct { int id; int data; int cyc; } expT;
    expT sbq[$];
    expT e;
    int nChecks = 0, nFail = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic setOp(int i, int a, int b, int c);
        REQ_A[i*P +: P] = P'(a);
        REQ_B[i*P +: P] = P'(b);
        REQ_C[i*P +: P] = P'(c);
    endtask

    task automatic expect_rsp(int id, int data, int at);
        expT x;
        x.id = id; x.data = data; x.cyc = at;
        sbq.push_back(x);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic int opA(int k); return (k * 13 + 7) % 256; endfunction
    function automatic int opB(int k); return k + 3; endfunction
    function automatic int opC(int g); return g * 5 + 1; endfunction

    // Monitor: every response must match the head of the scoreboard, including arrival cycle.
    always @(negedge C) begin
        if (RSP_VALID) begin
            if (sbq.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected_rsp: got id %0d data %0d at cycle %0d, required no response",
                         RSP_ID, RSP_DATA, cyc);
            end else begin
                e = sbq.pop_front();
                chk("rsp_id", 32'(RSP_ID), e.id);
                chk("rsp_data", 32'(RSP_DATA), e.data);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic chkAllZero(string tag);
        chk({tag, "_gnt"}, 32'(GNT), 0);
        chk({tag, "_a1"}, 32'(A1_O), 0);
        chk({tag, "_b1"}, 32'(B1_O), 0);
        chk({tag, "_c1"}, 32'(C1_O), 0);
        chk({tag, "_rspv"}, 32'(RSP_VALID), 0);
        chk({tag, "_rspid"}, 32'(RSP_ID), 0);
        chk({tag, "_rspdata"}, 32'(RSP_DATA), 0);
        chk({tag, "_fdone"}, 32'(FLUSH_DONE), 0);
        chk({tag, "_busy"}, 32'(BUSY), 0);
    endtask

    initial begin
        // Reset state, with requests already asserted
        EN = 1'b1;
        REQ = 4'b1111;
        #1;
        chkAllZero("reset");
        tick(); tick();
        REQ = '0;
        R = 1'b0;
        tick();

        // Fairness: all requesting, grants rotate 0,1,2,3,...
        for (int i = 0; i < N; i++) setOp(i, opA(i), opB(i), opC(i));
        REQ = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_gnt", 32'(GNT), 32'(1) << (k % N));
            expect_rsp(k % N, opA(k) * opB(k) + opC(k % N), cyc + 6);
            tick();
            setOp(k % N, opA(k + N), opB(k + N), opC(k % N));
        end
        REQ = '0;
        idle(8);

        // Single op on requester 2: 7*9+5
        setOp(2, 7, 9, 5);
        REQ = 4'b0100;
        #1;
        chk("single_gnt", 32'(GNT), 4);
        chk("single_busy0", 32'(BUSY), 0);
        expect_rsp(2, 68, cyc + 6);
        tick();
        REQ = '0;
        chk("single_a1", 32'(A1_O), 7);
        for (int j = 1; j <= 6; j++) begin
            chk("single_busy", 32'(BUSY), 1);
            tick();
        end
        chk("single_busy_fall", 32'(BUSY), 0);
        idle(2);

        // Max operands, then an 8-op stream from requester 1
        setOp(0, 255, 255, 255);
        REQ = 4'b0001;
        #1;
        chk("max_gnt", 32'(GNT), 1);
        expect_rsp(0, 65280, cyc + 6);
        tick();
        REQ = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            setOp(1, k + 1, 2 * k + 1, k);
            #1;
            chk("stream_gnt", 32'(GNT), 2);
            expect_rsp(1, (k + 1) * (2 * k + 1) + k, cyc + 6);
            tick();
        end
        REQ = '0;
        idle(8);

        // EN gating: three blocked cycles, operand registers hold the last issue
        EN = 1'b0;
        REQ = 4'b0001;
        setOp(0, 3, 4, 5);
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("en_gnt_blocked", 32'(GNT), 0);
            tick();
            chk("en_a1_hold", 32'(A1_O), 8);
            chk("en_b1_hold", 32'(B1_O), 15);
        end
        EN = 1'b1;
        #1;
        chk("en_gnt", 32'(GNT), 1);
        expect_rsp(0, 17, cyc + 6);
        tick();
        REQ = '0;
        chk("en_a1", 32'(A1_O), 3);
        idle(8);

        // Flush: pointer sits at 1, grants 1 then 2, FLUSH in cycle 2
        setOp(0, 2, 3, 4);
        setOp(1, 5, 6, 7);
        setOp(2, 10, 11, 12);
        REQ = 4'b0111;
        #1;
        chk("flush_gnt0", 32'(GNT), 2);
        expect_rsp(1, 37, cyc + 6);
        tick();
        REQ = 4'b0101;
        #1;
        chk("flush_gnt1", 32'(GNT), 4);
        expect_rsp(2, 122, cyc + 6);
        tick();
        REQ = 4'b0001;
        FLUSH = 1'b1;
        #1;
        chk("flush_gnt2", 32'(GNT), 0);
        chk("flush_done2", 32'(FLUSH_DONE), 0);
        tick();
        FLUSH = 1'b0;
        for (int c = 3; c <= 9; c++) begin
            #1;
            chk("drain_gnt", 32'(GNT), 0);
            chk("drain_fdone", 32'(FLUSH_DONE), (c == 9) ? 1 : 0);
            tick();
        end
        #1;
        chk("resume_gnt", 32'(GNT), 1);
        chk("resume_fdone", 32'(FLUSH_DONE), 0);
        expect_rsp(0, 10, cyc + 6);
        tick();
        REQ = '0;
        idle(8);

        // Reset mid-operation: two ops from requester 2 are lost
        setOp(2, 20, 3, 1);
        setOp(1, 6, 7, 8);
        REQ = 4'b0100;
        #1;
        chk("rst_gnt0", 32'(GNT), 4);
        tick();
        #1;
        chk("rst_gnt1", 32'(GNT), 4);
        tick();
        REQ = '0;
        tick();
        R = 1'b1;
        REQ = 4'b1010;
        #1;
        chkAllZero("rst_during");
        tick();
        chkAllZero("rst_held");
        R = 1'b0;
        #1;
        chk("rst_after_gnt", 32'(GNT), 2);
        chk("rst_after_rspdata", 32'(RSP_DATA), 0);
        expect_rsp(1, 50, cyc + 6);
        tick();
        REQ = '0;
        idle(10);

        chk("scoreboard_empty", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
